fetch_redirect_unit: RTL and testbench

- IF stage plus IF/ID pipeline register for the 5-stage MIPS datapath.
- Holds the PC, issues fetch addresses, and registers instruction/PC+4 into IF/ID.
- Consumes the ID-stage branch-compare result and jump controls to redirect the PC and flush the wrong-path instruction.
- Feeds the ID-stage decoder, register file and branch comparator.

---
 rtl/fetch_redirect_unit_pkg.sv | 18 +
 rtl/fetch_redirect_unit_next_pc_select.sv | 55 +++++
 rtl/fetch_redirect_unit.sv | 95 +++++++++
 tb/tb_fetch_redirect_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_unit_pkg.sv
// Shared definitions for the fetch/redirect slice: opcodes, the default NOP word
// and the next-PC source selector.
package fetch_redirect_unit_pkg;

  localparam logic [5:0]  OP_BEQ   = 6'b000100;
  localparam logic [5:0]  OP_BNE   = 6'b000101;
  localparam logic [5:0]  OP_J     = 6'b000010;
  localparam logic [5:0]  OP_JAL   = 6'b000011;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_BR  = 2'd1,
    SEL_J   = 2'd2,
    SEL_JR  = 2'd3
  } sel_e;

endpackage

// File: rtl/fetch_redirect_unit_next_pc_select.sv
// Combinational next-PC logic: decides whether the instruction in ID redirects
// fetch and computes the PC to load at the next edge.
module next_pc_select
  import fetch_redirect_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] if_id_instr,
  input  logic [31:0] if_id_pcplus4,
  input  logic        if_id_valid,
  input  logic        branch,
  input  logic        branch_cmp,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] jump_reg_target,
  output logic        redirect,
  output sel_e        sel,
  output logic [31:0] next_pc
);

  logic        is_bne_s;
  logic        br_taken_s;
  logic [31:0] br_target_s;
  logic [31:0] j_target_s;

  // Taken decode and source selection; a bubble in IF/ID never redirects
  always_comb begin
    is_bne_s    = (if_id_instr[31:26] == OP_BNE);
    br_taken_s  = branch & if_id_valid & (branch_cmp ^ is_bne_s);
    br_target_s = if_id_pcplus4 + {{14{if_id_instr[15]}}, if_id_instr[15:0], 2'b00};
    j_target_s  = {if_id_pcplus4[31:28], if_id_instr[25:0], 2'b00};
    sel         = SEL_SEQ;
    if (jump_reg & if_id_valid) begin
      sel = SEL_JR;
    end else if (jump & if_id_valid) begin
      sel = SEL_J;
    end else if (br_taken_s) begin
      sel = SEL_BR;
    end else begin
      sel = SEL_SEQ;
    end
    redirect = (sel != SEL_SEQ);
  end

  // Target mux
  always_comb begin
    case (sel)
      SEL_JR:  next_pc = jump_reg_target;
      SEL_J:   next_pc = j_target_s;
      SEL_BR:  next_pc = br_target_s;
      SEL_SEQ: next_pc = pc + 32'd4;
      default: next_pc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// IF stage and IF/ID pipeline register: holds the PC, fetches sequentially,
// and redirects/flushes on taken branches and jumps resolved in ID.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          DELAY_SLOT = 0,
  parameter logic [31:0] NOP_WORD   = fetch_redirect_unit_pkg::NOP_WORD
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] InstrData,
  input  logic        InstrValid,
  input  logic        Stall,
  input  logic        BranchCmp,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        JumpReg,
  input  logic [31:0] JumpRegTarget,
  output logic [31:0] InstrAddr,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [15:0] RedirectCount
);

  logic [31:0] pc_r;
  logic [31:0] if_id_instr_r;
  logic [31:0] if_id_pcplus4_r;
  logic        if_id_valid_r;
  logic [15:0] redirect_count_r;
  logic        redirect_s;
  sel_e        sel_s;
  logic [31:0] next_pc_s;

  next_pc_select u_next_pc_select (
    .pc              (pc_r),
    .if_id_instr     (if_id_instr_r),
    .if_id_pcplus4   (if_id_pcplus4_r),
    .if_id_valid     (if_id_valid_r),
    .branch          (Branch),
    .branch_cmp      (BranchCmp),
    .jump            (Jump),
    .jump_reg        (JumpReg),
    .jump_reg_target (JumpRegTarget),
    .redirect        (redirect_s),
    .sel             (sel_s),
    .next_pc         (next_pc_s)
  );

  // PC, IF/ID and redirect counter; stall outranks redirect because ID operands may not be final
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      pc_r             <= RESET_PC;
      if_id_instr_r    <= NOP_WORD;
      if_id_pcplus4_r  <= 32'h0000_0000;
      if_id_valid_r    <= 1'b0;
      redirect_count_r <= 16'h0000;
    end else if (Stall) begin
      pc_r             <= pc_r;
      if_id_instr_r    <= if_id_instr_r;
      if_id_pcplus4_r  <= if_id_pcplus4_r;
      if_id_valid_r    <= if_id_valid_r;
      redirect_count_r <= redirect_count_r;
    end else if (redirect_s) begin
      pc_r <= next_pc_s;
      if (redirect_count_r != 16'hFFFF) begin
        redirect_count_r <= redirect_count_r + 16'd1;
      end
      if ((DELAY_SLOT != 0) && InstrValid) begin
        if_id_instr_r   <= InstrData;
        if_id_pcplus4_r <= pc_r + 32'd4;
        if_id_valid_r   <= 1'b1;
      end else begin
        if_id_instr_r   <= NOP_WORD;
        if_id_valid_r   <= 1'b0;
      end
    end else if (!InstrValid) begin
      if_id_instr_r <= NOP_WORD;
      if_id_valid_r <= 1'b0;
    end else begin
      pc_r            <= next_pc_s;
      if_id_instr_r   <= InstrData;
      if_id_pcplus4_r <= pc_r + 32'd4;
      if_id_valid_r   <= 1'b1;
    end
  end

  assign InstrAddr     = pc_r;
  assign IF_ID_Instr   = if_id_instr_r;
  assign IF_ID_PCPlus4 = if_id_pcplus4_r;
  assign IF_ID_Valid   = if_id_valid_r;
  assign RedirectCount = redirect_count_r;

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Self-checking bench: two instances (no delay slot / delay slot) driven with the
// same directed and random stimulus, compared against an arithmetic reference model.
module tb_fetch_redirect_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        Clk;
  logic        Rst;
  logic [31:0] InstrData;
  logic        InstrValid, Stall, BranchCmp, Branch, Jump, JumpReg;
  logic [31:0] JumpRegTarget;

  logic [31:0] addr_o  [2];
  logic [31:0] instr_o [2];
  logic [31:0] pc4_o   [2];
  logic        valid_o [2];
  logic [15:0] cnt_o   [2];

  // reference model state, index = DELAY_SLOT
  logic [31:0] m_pc    [2];
  logic [31:0] m_instr [2];
  logic [31:0] m_pc4   [2];
  logic        m_valid [2];
  int          m_cnt   [2];

  int checks = 0;
  int failures = 0;

  fetch_redirect_unit #(.RESET_PC(RPC), .DELAY_SLOT(0), .NOP_WORD(32'h0000_0000)) dut0 (
    .Clk(Clk), .Rst(Rst), .InstrData(InstrData), .InstrValid(InstrValid), .Stall(Stall),
    .BranchCmp(BranchCmp), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
    .JumpRegTarget(JumpRegTarget), .InstrAddr(addr_o[0]), .IF_ID_Instr(instr_o[0]),
    .IF_ID_PCPlus4(pc4_o[0]), .IF_ID_Valid(valid_o[0]), .RedirectCount(cnt_o[0]));

  fetch_redirect_unit #(.RESET_PC(RPC), .DELAY_SLOT(1), .NOP_WORD(32'h0000_0000)) dut1 (
    .Clk(Clk), .Rst(Rst), .InstrData(InstrData), .InstrValid(InstrValid), .Stall(Stall),
    .BranchCmp(BranchCmp), .Branch(Branch), .Jump(Jump), .JumpReg(JumpReg),
    .JumpRegTarget(JumpRegTarget), .InstrAddr(addr_o[1]), .IF_ID_Instr(instr_o[1]),
    .IF_ID_PCPlus4(pc4_o[1]), .IF_ID_Valid(valid_o[1]), .RedirectCount(cnt_o[1]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = RPC; m_instr[k] = 32'h0; m_pc4[k] = 32'h0; m_valid[k] = 1'b0; m_cnt[k] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_addr%0d", tag, k), addr_o[k], m_pc[k]);
      chk($sformatf("%s_instr%0d", tag, k), instr_o[k], m_instr[k]);
      chk($sformatf("%s_pc4_%0d", tag, k), pc4_o[k], m_pc4[k]);
      chk($sformatf("%s_valid%0d", tag, k), {31'b0, valid_o[k]}, {31'b0, m_valid[k]});
      chk($sformatf("%s_cnt%0d", tag, k), {16'b0, cnt_o[k]}, m_cnt[k]);
    end
  endtask

  // Apply one cycle of inputs, advance the model, optionally compare everything.
  task automatic step(input logic iv, input logic st, input logic br, input logic cmp,
                      input logic j, input logic jr, input logic [31:0] data,
                      input logic [31:0] jrt, input bit do_chk, input string tag);
    logic        taken;
    logic [31:0] tgt;
    int          off;
    InstrValid = iv; Stall = st; Branch = br; BranchCmp = cmp;
    Jump = j; JumpReg = jr; InstrData = data; JumpRegTarget = jrt;
    @(posedge Clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (st) continue;
      off = $signed(m_instr[k][15:0]) * 4;
      if (m_valid[k] && jr) begin
        taken = 1'b1; tgt = jrt;
      end else if (m_valid[k] && j) begin
        taken = 1'b1; tgt = {m_pc4[k][31:28], m_instr[k][25:0], 2'b00};
      end else if (m_valid[k] && br && (cmp != (m_instr[k][31:26] == 6'd5))) begin
        taken = 1'b1; tgt = m_pc4[k] + 32'(off);
      end else begin
        taken = 1'b0; tgt = 32'h0;
      end
      if (taken) begin
        if (m_cnt[k] < 65535) m_cnt[k]++;
        if (k == 1 && iv) begin
          m_instr[k] = data; m_pc4[k] = m_pc[k] + 32'd4; m_valid[k] = 1'b1;
        end else begin
          m_instr[k] = 32'h0; m_valid[k] = 1'b0;
        end
        m_pc[k] = tgt;
      end else if (!iv) begin
        m_instr[k] = 32'h0; m_valid[k] = 1'b0;
      end else begin
        m_instr[k] = data; m_pc4[k] = m_pc[k] + 32'd4; m_valid[k] = 1'b1;
        m_pc[k] = m_pc[k] + 32'd4;
      end
    end
    if (do_chk) check_all(tag);
  endtask

  localparam logic [31:0] ADDI  = 32'h2008_0001;
  localparam logic [31:0] BEQ_M2 = 32'h1000_FFFE;
  localparam logic [31:0] BNE_4  = 32'h1400_0004;
  localparam logic [31:0] BEQ_8  = 32'h1000_0008;

  initial begin
    logic [31:0] held_pc;
    logic [31:0] rd;
    logic [5:0]  ops [4];
    ops[0] = 6'd4; ops[1] = 6'd5; ops[2] = 6'd2; ops[3] = 6'd8;

    Rst = 1'b1; InstrData = 32'h0; InstrValid = 1'b0; Stall = 1'b0; BranchCmp = 1'b0;
    Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0; JumpRegTarget = 32'h0;
    model_reset();
    #12;
    chk("rst_addr", addr_o[0], 32'h0000_0100);
    chk("rst_valid", {31'b0, valid_o[0]}, 32'h0);
    chk("rst_cnt", {16'b0, cnt_o[0]}, 32'h0);
    check_all("rst");
    Rst = 1'b0;

    // sequential fetch
    step(1, 0, 0, 0, 0, 0, ADDI, 32'h0, 1, "seq1");
    chk("seq1_addr", addr_o[0], 32'h0000_0104);
    step(1, 0, 0, 0, 0, 0, ADDI, 32'h0, 1, "seq2");
    chk("seq2_pc4", pc4_o[0], 32'h0000_0108);
    step(1, 0, 0, 0, 0, 0, ADDI, 32'h0, 1, "seq3");
    chk("seq3_addr", addr_o[0], 32'h0000_010C);

    // asynchronous reset pulse mid-cycle, with redirect conditions present
    Jump = 1'b1;
    #3 Rst = 1'b1;
    #1;
    model_reset();
    chk("midrst_addr", addr_o[0], 32'h0000_0100);
    chk("midrst_valid", {31'b0, valid_o[0]}, 32'h0);
    check_all("midrst");
    #1 Rst = 1'b0;

    // beq taken at PCPlus4=0x108, imm=-2
    step(1, 0, 0, 0, 0, 0, ADDI, 32'h0, 1, "pre_beq");
    step(1, 0, 0, 0, 0, 0, BEQ_M2, 32'h0, 1, "load_beq");
    chk("load_beq_pc4", pc4_o[0], 32'h0000_0108);
    step(1, 0, 1, 1, 0, 0, ADDI, 32'h0, 1, "beq");
    chk("beq_addr", addr_o[0], 32'h0000_0100);
    chk("beq_flush", {31'b0, valid_o[0]}, 32'h0);
    chk("beq_cnt", {16'b0, cnt_o[0]}, 32'h1);
    chk("beq_ds_valid", {31'b0, valid_o[1]}, 32'h1);

    // bne: equal operands -> fall through, unequal -> redirect
    step(1, 0, 0, 0, 0, 0, BNE_4, 32'h0, 1, "load_bne");
    step(1, 0, 1, 1, 0, 0, BNE_4, 32'h0, 1, "bne_nt");
    chk("bne_nt_addr", addr_o[0], 32'h0000_0108);
    step(1, 0, 1, 0, 0, 0, ADDI, 32'h0, 1, "bne_t");
    chk("bne_t_addr", addr_o[0], 32'h0000_0118);
    chk("bne_t_cnt", {16'b0, cnt_o[0]}, 32'h2);

    // stall with taken conditions, then release
    step(1, 0, 0, 0, 0, 0, BEQ_8, 32'h0, 1, "load_beq8");
    held_pc = m_pc[0];
    step(1, 1, 1, 1, 0, 0, ADDI, 32'h0, 1, "stall");
    chk("stall_addr", addr_o[0], held_pc);
    chk("stall_cnt", {16'b0, cnt_o[0]}, 32'h2);
    step(1, 0, 1, 1, 0, 0, ADDI, 32'h0, 1, "unstall");
    chk("unstall_addr", addr_o[0], held_pc + 32'd32);

    // jr beats j
    step(1, 0, 0, 0, 0, 0, 32'h0800_1234, 32'h0, 1, "load_j");
    step(1, 0, 0, 0, 1, 1, ADDI, 32'h0040_0000, 1, "jr");
    chk("jr_addr", addr_o[0], 32'h0040_0000);

    // bubbles never redirect
    step(0, 0, 0, 0, 0, 0, ADDI, 32'h0, 1, "bubble");
    step(1, 0, 1, 0, 1, 1, ADDI, 32'h0000_0800, 1, "bubble_noredir");

    // PC wrap
    step(1, 0, 0, 0, 0, 0, ADDI, 32'h0, 1, "pre_wrap");
    step(1, 0, 0, 0, 0, 1, ADDI, 32'hFFFF_FFFC, 1, "jr_top");
    step(1, 0, 0, 0, 0, 0, ADDI, 32'h0, 1, "wrap");
    chk("wrap_addr", addr_o[0], 32'h0000_0000);

    // randomized stimulus
    for (int i = 0; i < 400; i++) begin
      rd = $urandom;
      rd[31:26] = ops[$urandom_range(0, 3)];
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0), 1'($urandom),
           1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
           rd, $urandom, 1, "rnd");
    end

    // saturation: delay-slot instance redirects every cycle on a held jump
    for (int i = 0; i < 65540; i++) begin
      step(1, 0, 0, 0, 1, 0, 32'h0800_0040, 32'h0, (i % 16384 == 0), "sat_loop");
    end
    check_all("sat");
    chk("sat_cnt1", {16'b0, cnt_o[1]}, 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
